// File: rtl/rnm_edge_monitor.sv
// -----------------------------------------------------------------------------
// rnm_edge_monitor
//
// Receive-side monitor for a real-number-modelled analog node. vin is sampled
// on every rising clock edge. Hysteresis thresholds turn the sample into a
// clean digital level. Rise and fall transition times are measured in samples.
// Aborted transitions (glitches) and stuck transitions (timeouts) are flagged.
//
// Ports
//   clk          sampling clock; all state updates on the rising edge
//   rst_n        synchronous reset, active low
//   en           sample enable; when 0, state holds and pulses are 0
//   vin          monitored analog voltage (real)
//   dig_out      hysteresis-resolved logic level
//   rise_valid   1-cycle pulse: rise measurement complete
//   rise_cycles  in-band samples of the last completed rise
//   fall_valid   1-cycle pulse: fall measurement complete
//   fall_cycles  in-band samples of the last completed fall
//   edge_cnt     completed rises plus falls, wraps modulo 2^CNT_W
//   glitch       1-cycle pulse: transition returned to its origin rail
//   timeout      1-cycle pulse: transition stayed in band longer than TIMEOUT
// -----------------------------------------------------------------------------
module rnm_edge_monitor #(
  parameter real VDD     = 1.8,
  parameter real VSS     = 0.0,
  parameter real LO_FRAC = 0.1,
  parameter real HI_FRAC = 0.9,
  parameter int  CNT_W   = 16,
  parameter int  TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  real              vin,
  output logic             dig_out,
  output logic             rise_valid,
  output logic [CNT_W-1:0] rise_cycles,
  output logic             fall_valid,
  output logic [CNT_W-1:0] fall_cycles,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             glitch,
  output logic             timeout
);

  localparam real V_LO = VSS + LO_FRAC * (VDD - VSS);
  localparam real V_HI = VSS + HI_FRAC * (VDD - VSS);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_UNKNOWN,
    S_LOW,
    S_RISING,
    S_HIGH,
    S_FALLING
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dig_q, dig_d;
  logic [CNT_W-1:0] rise_cyc_q, rise_cyc_d;
  logic [CNT_W-1:0] fall_cyc_q, fall_cyc_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             rise_v_q, rise_v_d;
  logic             fall_v_q, fall_v_d;
  logic             glitch_q, glitch_d;
  logic             tmo_q, tmo_d;

  // Sample classification. The band boundaries are asymmetric on purpose:
  // exactly V_LO counts as low and exactly V_HI counts as high.
  logic is_low, is_high, above_lo, below_hi, at_limit;

  assign is_low   = (vin <= V_LO);
  assign is_high  = (vin >= V_HI);
  assign above_lo = (vin >  V_LO);
  assign below_hi = (vin <  V_HI);
  assign at_limit = (cnt_q == CNT_LIMIT);

  // ---------------------------------------------------------------------------
  // State register (plus the registered datapath and output pulses)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_UNKNOWN;
      cnt_q      <= '0;
      dig_q      <= 1'b0;
      rise_cyc_q <= '0;
      fall_cyc_q <= '0;
      edge_q     <= '0;
      rise_v_q   <= 1'b0;
      fall_v_q   <= 1'b0;
      glitch_q   <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      rise_cyc_q <= rise_cyc_d;
      fall_cyc_q <= fall_cyc_d;
      edge_q     <= edge_d;
      rise_v_q   <= rise_v_d;
      fall_v_q   <= fall_v_d;
      glitch_q   <= glitch_d;
      tmo_q      <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Inside a transition band the priority is
  // completion > abort > timeout > keep counting.
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every variable it
  // drives before any branch, which keeps synthesis from inferring latches.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_UNKNOWN: begin
          if (is_low)       state_d = S_LOW;
          else if (is_high) state_d = S_HIGH;
        end
        S_LOW: begin
          if (is_high)       state_d = S_HIGH;
          else if (above_lo) state_d = S_RISING;
        end
        S_RISING: begin
          if (is_high)       state_d = S_HIGH;
          else if (is_low)   state_d = S_LOW;
          else if (at_limit) state_d = S_UNKNOWN;
        end
        S_HIGH: begin
          if (is_low)        state_d = S_LOW;
          else if (below_hi) state_d = S_FALLING;
        end
        S_FALLING: begin
          if (is_low)        state_d = S_LOW;
          else if (is_high)  state_d = S_HIGH;
          else if (at_limit) state_d = S_UNKNOWN;
        end
        default: state_d = S_UNKNOWN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic: next values of the level, counters and pulses.
  // Pulses default to 0, so en=0 holds everything and silences the pulses.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    rise_cyc_d = rise_cyc_q;
    fall_cyc_d = fall_cyc_q;
    edge_d     = edge_q;
    rise_v_d   = 1'b0;
    fall_v_d   = 1'b0;
    glitch_d   = 1'b0;
    tmo_d      = 1'b0;
    if (en) begin
      unique case (state_q)
        S_UNKNOWN: begin
          // Settling onto a rail sets the level but is not a measured edge.
          if (is_low)       dig_d = 1'b0;
          else if (is_high) dig_d = 1'b1;
        end
        S_LOW: begin
          if (is_high) begin
            rise_v_d   = 1'b1;
            rise_cyc_d = '0;
            edge_d     = edge_q + CNT_ONE;
            dig_d      = 1'b1;
          end else if (above_lo) begin
            cnt_d = CNT_ONE;
          end
        end
        S_RISING: begin
          if (is_high) begin
            rise_v_d   = 1'b1;
            rise_cyc_d = cnt_q;
            edge_d     = edge_q + CNT_ONE;
            dig_d      = 1'b1;
          end else if (is_low) begin
            glitch_d = 1'b1;
          end else if (at_limit) begin
            tmo_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (is_low) begin
            fall_v_d   = 1'b1;
            fall_cyc_d = '0;
            edge_d     = edge_q + CNT_ONE;
            dig_d      = 1'b0;
          end else if (below_hi) begin
            cnt_d = CNT_ONE;
          end
        end
        S_FALLING: begin
          if (is_low) begin
            fall_v_d   = 1'b1;
            fall_cyc_d = cnt_q;
            edge_d     = edge_q + CNT_ONE;
            dig_d      = 1'b0;
          end else if (is_high) begin
            glitch_d = 1'b1;
          end else if (at_limit) begin
            tmo_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign dig_out     = dig_q;
  assign rise_valid  = rise_v_q;
  assign rise_cycles = rise_cyc_q;
  assign fall_valid  = fall_v_q;
  assign fall_cycles = fall_cyc_q;
  assign edge_cnt    = edge_q;
  assign glitch      = glitch_q;
  assign timeout     = tmo_q;

endmodule
